x_cal_sweep_ctrl: RTL and testbench

//  Sequences a delay-line calibration sweep. Steps the one-hot variable-delay tap

---
 rtl/x_cal_sweep_ctrl_pkg.sv | 28 ++
 rtl/x_cal_sweep_ctrl_if.sv | 39 +++
 rtl/x_cal_sweep_ctrl_popcount.sv | 25 ++
 rtl/x_cal_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_x_cal_sweep_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/x_cal_sweep_ctrl_pkg.sv
// Shared types and width helpers for the delay-line calibration sweep.
// Optional feature macro: X_CAL_SWEEP_AVG_EN (multi-sample accumulation per tap).
package x_cal_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      ACCUM,
      REPORT
   } cal_state_t;

   // Width of a tap index; a single-tap line still needs one bit.
   function automatic int tap_w(input int taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

   // Width of a per-tap result: one popcount, or a sum of 2**avg_log2 popcounts.
   function automatic int cnt_w(input int dl_w, input int avg_log2);
`ifdef X_CAL_SWEEP_AVG_EN
      return $clog2(dl_w + 1) + avg_log2;
`else
      // avg_log2 only widens the result when averaging is built in
      return $clog2(dl_w + 1) + 0 * avg_log2;
`endif
   endfunction

endpackage

// File: rtl/x_cal_sweep_ctrl_if.sv
// Handshake/bus bundle between the sweep controller and its surroundings
// (delay-line tap select, capture register, result consumer).
// Optional feature macro affecting widths: X_CAL_SWEEP_AVG_EN.
interface x_cal_sweep_ctrl_if
   import x_cal_pkg::*;
#(
   parameter int P_TAPS = 256,
   parameter int P_DL_W = 256,
   parameter int CNT_W  = 9
);
   localparam int TAP_W = tap_w(P_TAPS);

   logic                i_start;
   logic                i_abort;
   logic [P_TAPS-1:0]   o_ctrl;
   logic [TAP_W-1:0]    o_tap;
   logic                o_cap_en;
   logic [P_DL_W-1:0]   i_data;
   logic                o_res_valid;
   logic                i_res_ready;
   logic [TAP_W-1:0]    o_res_tap;
   logic [CNT_W-1:0]    o_res_count;
   logic                o_busy;
   logic                o_done;

   // Controller side
   modport master (
      input  i_start, i_abort, i_data, i_res_ready,
      output o_ctrl, o_tap, o_cap_en, o_res_valid, o_res_tap, o_res_count,
             o_busy, o_done
   );

   // Environment side (control, delay line, result consumer)
   modport slave (
      output i_start, i_abort, i_data, i_res_ready,
      input  o_ctrl, o_tap, o_cap_en, o_res_valid, o_res_tap, o_res_count,
             o_busy, o_done
   );
endinterface

// File: rtl/x_cal_sweep_ctrl_popcount.sv
// Combinational popcount as a recursive adder tree: each node splits the word
// in half and adds the two sub-counts.
module x_popcount #(
   parameter  int P_W = 8,
   localparam int C_W = $clog2(P_W + 1)
) (
   input  logic [P_W-1:0] i_data,
   output logic [C_W-1:0] o_cnt
);
   generate
      if (P_W == 1) begin : g_leaf
         assign o_cnt = i_data;
      end else begin : g_node
         localparam int LO_W = P_W / 2;
         localparam int HI_W = P_W - LO_W;
         localparam int LO_C = $clog2(LO_W + 1);
         localparam int HI_C = $clog2(HI_W + 1);
         logic [LO_C-1:0] lo_cnt;
         logic [HI_C-1:0] hi_cnt;
         x_popcount #(.P_W(LO_W)) u_lo (.i_data(i_data[LO_W-1:0]),   .o_cnt(lo_cnt));
         x_popcount #(.P_W(HI_W)) u_hi (.i_data(i_data[P_W-1:LO_W]), .o_cnt(hi_cnt));
         assign o_cnt = C_W'(lo_cnt) + C_W'(hi_cnt);
      end
   endgenerate
endmodule

// File: rtl/x_cal_sweep_ctrl.sv
// Delay-line calibration sweep controller. Steps a one-hot tap select over all
// taps, waits for the line to settle, strobes the capture register, popcounts
// the captured thermometer word and offers {tap,count} on a valid/ready port.
// Optional feature macro: X_CAL_SWEEP_AVG_EN -- 2**P_AVG_LOG2 capture/accumulate
// pairs per tap (no re-settle between them); the raw sum is reported.
module x_cal_sweep_ctrl
   import x_cal_pkg::*;
#(
   parameter int P_TAPS     = 256,
   parameter int P_DL_W     = 256,
   parameter int P_SETTLE   = 16,
   parameter int P_AVG_LOG2 = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   x_cal_sweep_ctrl_if.master bus
);
   localparam int TAP_W = tap_w(P_TAPS);
   localparam int CNT_W = cnt_w(P_DL_W, P_AVG_LOG2);
   localparam int PC_W  = $clog2(P_DL_W + 1);
   localparam int SET_W = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
   localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(P_TAPS - 1);
   localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(P_SETTLE - 1);

   cal_state_t       state_q, state_d;
   logic [TAP_W-1:0] tap_q, res_tap_q;
   logic [SET_W-1:0] settle_q;
   logic [CNT_W-1:0] acc_q, acc_sum, res_count_q;
   logic [PC_W-1:0]  pop;
   logic             done_q;
   logic             last_smp, abort_go, xfer;
   logic             cap_en, res_valid, busy;

   x_popcount #(.P_W(P_DL_W)) u_pop (.i_data(bus.i_data), .o_cnt(pop));

   assign acc_sum  = acc_q + CNT_W'(pop);
   assign abort_go = bus.i_abort && (state_q != IDLE);
   // abort takes priority over a result transfer in the same cycle
   assign xfer     = (state_q == REPORT) && bus.i_res_ready && !bus.i_abort;

`ifdef X_CAL_SWEEP_AVG_EN
   localparam int SMP_W = (P_AVG_LOG2 > 0) ? P_AVG_LOG2 : 1;
   logic [SMP_W-1:0] smp_q;
   assign last_smp = (smp_q == SMP_W'((1 << P_AVG_LOG2) - 1));

   // Sample index within the current tap; wraps to 0 after the last sample.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                smp_q <= '0;
      else if (abort_go)        smp_q <= '0;
      else if (state_q == ACCUM) smp_q <= last_smp ? '0 : smp_q + 1'b1;
   end
`else
   assign last_smp = 1'b1;
`endif

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_d   = state_q;
      cap_en    = 1'b0;
      res_valid = 1'b0;
      busy      = (state_q != IDLE);
      if (abort_go) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.i_start && !bus.i_abort) state_d = SETTLE;
            SETTLE:  if (settle_q == '0) state_d = CAPTURE;
            CAPTURE: state_d = ACCUM;
            ACCUM:   state_d = last_smp ? REPORT : CAPTURE;
            REPORT:  if (xfer) state_d = (tap_q == LAST_TAP) ? IDLE : SETTLE;
            default: state_d = IDLE;
         endcase
      end
      // strobe and valid stay asserted in their state even in an abort cycle
      cap_en    = (state_q == CAPTURE);
      res_valid = (state_q == REPORT);
   end

   // Tap stepping, settle countdown, accumulation and result capture.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tap_q       <= '0;
         settle_q    <= '0;
         acc_q       <= '0;
         res_tap_q   <= '0;
         res_count_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_go) begin
            tap_q <= '0;
            acc_q <= '0;
         end else begin
            case (state_q)
               IDLE: if (bus.i_start && !bus.i_abort) begin
                  tap_q    <= '0;
                  settle_q <= SETTLE_INIT;
                  acc_q    <= '0;
               end
               SETTLE: if (settle_q != '0) settle_q <= settle_q - 1'b1;
               ACCUM: begin
                  acc_q <= acc_sum;
                  if (last_smp) begin
                     res_count_q <= acc_sum;
                     res_tap_q   <= tap_q;
                  end
               end
               REPORT: if (xfer) begin
                  acc_q    <= '0;
                  settle_q <= SETTLE_INIT;
                  if (tap_q == LAST_TAP) begin
                     tap_q  <= '0;
                     done_q <= 1'b1;
                  end else begin
                     tap_q <= tap_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.o_ctrl      = P_TAPS'(1) << tap_q;
   assign bus.o_tap       = tap_q;
   assign bus.o_cap_en    = cap_en;
   assign bus.o_res_valid = res_valid;
   assign bus.o_res_tap   = res_tap_q;
   assign bus.o_res_count = res_count_q;
   assign bus.o_busy      = busy;
   assign bus.o_done      = done_q;

endmodule

// File: tb/tb_x_cal_sweep_ctrl.sv
// Self-checking bench for x_cal_sweep_ctrl: random capture data, a negedge
// event recorder, and per-scenario tasks comparing against expectations
// derived from the sweep rules (results per tap = sum of captured popcounts).
module tb_x_cal_sweep_ctrl;
   import x_cal_pkg::*;

   localparam int P_TAPS = 4, P_DL_W = 8, P_SETTLE = 3, P_AVG_LOG2 = 2;
   localparam int TAP_W = tap_w(P_TAPS);
   localparam int CNT_W = cnt_w(P_DL_W, P_AVG_LOG2);
`ifdef X_CAL_SWEEP_AVG_EN
   localparam int NS = 1 << P_AVG_LOG2;
`else
   localparam int NS = 1;
`endif
   localparam int TAP_PERIOD = P_SETTLE + 2 * NS + 1;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   x_cal_sweep_ctrl_if #(.P_TAPS(P_TAPS), .P_DL_W(P_DL_W), .CNT_W(CNT_W)) bus();

   x_cal_sweep_ctrl #(
      .P_TAPS(P_TAPS), .P_DL_W(P_DL_W), .P_SETTLE(P_SETTLE), .P_AVG_LOG2(P_AVG_LOG2)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;

   // capture-data source: random or a fixed word, updated just after each edge
   bit                rnd_en = 1'b0;
   logic [P_DL_W-1:0] fixed_data = '0;
   always @(posedge i_clk) begin
      #1;
      bus.i_data = rnd_en ? P_DL_W'($urandom) : fixed_data;
   end

   // event recorder (no judgements, just what happened)
   typedef struct { int tap; int cnt; } xfer_t;
   xfer_t xfer_q[$];
   int    pop_q[$];
   int    tchg_q[$];
   int    cyc = 0, done_cnt = 0, ctrl_bad = 0, last_tap = 0;
   bit    cap_q = 1'b0;
   always @(negedge i_clk) begin
      xfer_t e;
      cyc++;
      if (cap_q) pop_q.push_back($countones(bus.i_data));
      cap_q = bus.o_cap_en;
      if (bus.o_res_valid && bus.i_res_ready && !bus.i_abort) begin
         e.tap = int'(bus.o_res_tap);
         e.cnt = int'(bus.o_res_count);
         xfer_q.push_back(e);
      end
      if (bus.o_done) done_cnt++;
      if (int'(bus.o_tap) != last_tap) begin
         tchg_q.push_back(cyc);
         last_tap = int'(bus.o_tap);
      end
      if (int'(bus.o_ctrl) != (1 << int'(bus.o_tap))) ctrl_bad++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.i_start = 1'b1;
      step(1);
      bus.i_start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         step(1);
         n++;
      end
      ok = (done_cnt != d0);
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      int n = 0;
      while (!bus.o_res_valid && n < budget) begin
         step(1);
         n++;
      end
      ok = bus.o_res_valid;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge i_clk);
      checks++;
      if (bus.o_ctrl !== 4'b0001 || bus.o_tap !== '0) begin
         failures++;
         $display("FAIL reset_tap ctrl=%b tap=%0d want ctrl=0001 tap=0", bus.o_ctrl, bus.o_tap);
      end
      checks++;
      if ({bus.o_res_valid, bus.o_busy, bus.o_done, bus.o_cap_en} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags valid=%b busy=%b done=%b cap=%b want 0000",
                  bus.o_res_valid, bus.o_busy, bus.o_done, bus.o_cap_en);
      end
      checks++;
      if (bus.o_res_count !== '0 || bus.o_res_tap !== '0) begin
         failures++;
         $display("FAIL reset_result count=%0d tap=%0d want 0 0", bus.o_res_count, bus.o_res_tap);
      end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      step(2);
   endtask

   task automatic test_sweep(input string name, input bit rnd, input logic [P_DL_W-1:0] d);
      int  x0, p0, t0, d0, b0, exp;
      bit  ok;
      rnd_en = rnd;
      fixed_data = d;
      bus.i_res_ready = 1'b1;
      step(2);
      x0 = xfer_q.size(); p0 = pop_q.size(); t0 = tchg_q.size();
      d0 = done_cnt; b0 = ctrl_bad;
      pulse_start();
      wait_done(d0, 400, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s done_timeout got=0 want=1", name);
      end
      step(4);
      checks++;
      if (done_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt - d0);
      end
      checks++;
      if (xfer_q.size() - x0 !== P_TAPS || pop_q.size() - p0 !== P_TAPS * NS) begin
         failures++;
         $display("FAIL %s results got=%0d caps=%0d want=%0d caps=%0d", name,
                  xfer_q.size() - x0, pop_q.size() - p0, P_TAPS, P_TAPS * NS);
      end else begin
         for (int k = 0; k < P_TAPS; k++) begin
            exp = 0;
            for (int j = 0; j < NS; j++) exp += pop_q[p0 + k * NS + j];
            checks++;
            if (xfer_q[x0 + k].tap !== k || xfer_q[x0 + k].cnt !== exp) begin
               failures++;
               $display("FAIL %s result[%0d] tap=%0d cnt=%0d want tap=%0d cnt=%0d", name, k,
                        xfer_q[x0 + k].tap, xfer_q[x0 + k].cnt, k, exp);
            end
            if (!rnd) begin
               checks++;
               if (xfer_q[x0 + k].cnt !== NS * $countones(d)) begin
                  failures++;
                  $display("FAIL %s fixed_count[%0d] got=%0d want=%0d", name, k,
                           xfer_q[x0 + k].cnt, NS * $countones(d));
               end
            end
         end
      end
      checks++;
      if (tchg_q.size() - t0 !== P_TAPS) begin
         failures++;
         $display("FAIL %s tap_changes got=%0d want=%0d", name, tchg_q.size() - t0, P_TAPS);
      end else begin
         for (int k = 1; k < P_TAPS; k++) begin
            checks++;
            if (tchg_q[t0 + k] - tchg_q[t0 + k - 1] !== TAP_PERIOD) begin
               failures++;
               $display("FAIL %s tap_period[%0d] got=%0d want=%0d", name, k,
                        tchg_q[t0 + k] - tchg_q[t0 + k - 1], TAP_PERIOD);
            end
         end
      end
      checks++;
      if (ctrl_bad !== b0 || bus.o_busy !== 1'b0 || bus.o_ctrl !== 4'b0001) begin
         failures++;
         $display("FAIL %s end_state onehot_errs=%0d busy=%b ctrl=%b want 0 0 0001", name,
                  ctrl_bad - b0, bus.o_busy, bus.o_ctrl);
      end
   endtask

   task automatic test_backpressure();
      int  p0, d0, exp, c;
      bit  ok;
      rnd_en = 1'b1;
      bus.i_res_ready = 1'b0;
      step(2);
      p0 = pop_q.size(); d0 = done_cnt;
      pulse_start();
      wait_valid(100, ok);
      bus.i_res_ready = 1'b1;
      step(1);
      bus.i_res_ready = 1'b0;
      step(1);
      wait_valid(100, ok);
      checks++;
      if (!ok || bus.o_res_tap !== 2'd1) begin
         failures++;
         $display("FAIL bp_reach_tap1 valid=%b tap=%0d want 1 1", bus.o_res_valid, bus.o_res_tap);
      end
      exp = 0;
      for (int j = 0; j < NS; j++) exp += pop_q[p0 + NS + j];
      c = int'(bus.o_res_count);
      checks++;
      if (c !== exp) begin
         failures++;
         $display("FAIL bp_count got=%0d want=%0d", c, exp);
      end
      for (int i = 0; i < 10; i++) begin
         step(1);
         checks++;
         if (bus.o_res_valid !== 1'b1 || bus.o_res_tap !== 2'd1 || int'(bus.o_res_count) !== exp ||
             bus.o_ctrl !== 4'b0010 || bus.o_cap_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold[%0d] valid=%b tap=%0d cnt=%0d ctrl=%b cap=%b want 1 1 %0d 0010 0",
                     i, bus.o_res_valid, bus.o_res_tap, bus.o_res_count, bus.o_ctrl, bus.o_cap_en, exp);
         end
      end
      bus.i_res_ready = 1'b1;
      wait_done(d0, 300, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_done got=0 want=1");
      end
      step(2);
   endtask

   task automatic test_abort();
      int  x0, d0, n;
      bit  ok;
      rnd_en = 1'b1;
      bus.i_res_ready = 1'b1;
      step(2);
      x0 = xfer_q.size(); d0 = done_cnt;
      pulse_start();
      n = 0;
      while (bus.o_tap !== 2'd2 && n < 100) begin step(1); n++; end
      checks++;
      if (bus.o_tap !== 2'd2 || bus.o_busy !== 1'b1 || bus.o_cap_en !== 1'b0) begin
         failures++;
         $display("FAIL abort_reach_tap2 tap=%0d busy=%b cap=%b want 2 1 0", bus.o_tap, bus.o_busy, bus.o_cap_en);
      end
      bus.i_abort = 1'b1;
      step(1);
      bus.i_abort = 1'b0;
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_ctrl !== 4'b0001 || bus.o_tap !== '0 || bus.o_res_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle busy=%b ctrl=%b tap=%0d valid=%b want 0 0001 0 0",
                  bus.o_busy, bus.o_ctrl, bus.o_tap, bus.o_res_valid);
      end
      step(40);
      checks++;
      if (done_cnt !== d0 || xfer_q.size() - x0 !== 2 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_after done=%0d results=%0d busy=%b want 0 2 0",
                  done_cnt - d0, xfer_q.size() - x0, bus.o_busy);
      end
   endtask

   task automatic test_abort_report();
      int  d0;
      bit  ok;
      bus.i_res_ready = 1'b0;
      step(2);
      d0 = done_cnt;
      pulse_start();
      wait_valid(100, ok);
      bus.i_res_ready = 1'b1;
      bus.i_abort = 1'b1;
      step(1);
      bus.i_abort = 1'b0;
      checks++;
      if (!ok || bus.o_busy !== 1'b0 || bus.o_tap !== '0 || bus.o_res_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_report reached=%b busy=%b tap=%0d valid=%b want 1 0 0 0",
                  ok, bus.o_busy, bus.o_tap, bus.o_res_valid);
      end
      step(20);
      checks++;
      if (done_cnt !== d0 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_report_after done=%0d busy=%b want 0 0", done_cnt - d0, bus.o_busy);
      end
   endtask

   task automatic test_start_ignored();
      int  x0, t0, d0;
      bit  ok;
      rnd_en = 1'b1;
      bus.i_res_ready = 1'b1;
      step(2);
      x0 = xfer_q.size(); t0 = tchg_q.size(); d0 = done_cnt;
      pulse_start();
      step(4);
      pulse_start();
      step(7);
      pulse_start();
      wait_done(d0, 300, ok);
      step(2);
      checks++;
      if (!ok || done_cnt - d0 !== 1 || xfer_q.size() - x0 !== P_TAPS) begin
         failures++;
         $display("FAIL restart_sweep done=%0d results=%0d want 1 %0d", done_cnt - d0,
                  xfer_q.size() - x0, P_TAPS);
      end else begin
         for (int k = 0; k < P_TAPS; k++) begin
            checks++;
            if (xfer_q[x0 + k].tap !== k) begin
               failures++;
               $display("FAIL restart_tap[%0d] got=%0d want=%0d", k, xfer_q[x0 + k].tap, k);
            end
         end
      end
      checks++;
      if (tchg_q.size() - t0 !== P_TAPS ||
          tchg_q[t0 + P_TAPS - 1] - tchg_q[t0] !== (P_TAPS - 1) * TAP_PERIOD) begin
         failures++;
         $display("FAIL restart_timing changes=%0d want=%0d period_sum want=%0d", tchg_q.size() - t0,
                  P_TAPS, (P_TAPS - 1) * TAP_PERIOD);
      end
      bus.i_start = 1'b1;
      bus.i_abort = 1'b1;
      step(1);
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      checks++;
      if (bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL start_abort_idle busy=%b want 0", bus.o_busy);
      end
      step(6);
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_tap !== '0 || done_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL start_abort_stay busy=%b tap=%0d done=%0d want 0 0 1", bus.o_busy, bus.o_tap,
                  done_cnt - d0);
      end
   endtask

   task automatic test_async_reset();
      rnd_en = 1'b1;
      bus.i_res_ready = 1'b1;
      step(2);
      pulse_start();
      step(P_SETTLE + 3 + 2);
      @(negedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_ctrl !== 4'b0001 || bus.o_tap !== '0 ||
          bus.o_res_valid !== 1'b0 || bus.o_cap_en !== 1'b0 || bus.o_res_count !== '0) begin
         failures++;
         $display("FAIL async_reset busy=%b ctrl=%b tap=%0d valid=%b cap=%b cnt=%0d want 0 0001 0 0 0 0",
                  bus.o_busy, bus.o_ctrl, bus.o_tap, bus.o_res_valid, bus.o_cap_en, bus.o_res_count);
      end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      step(2);
   endtask

   initial begin
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_res_ready = 1'b0;
      test_reset();
      test_sweep("sweep_0f", 1'b0, 8'h0F);
      test_sweep("sweep_ff", 1'b0, 8'hFF);
      test_sweep("sweep_rnd", 1'b1, 8'h00);
      test_backpressure();
      test_abort();
      test_abort_report();
      test_start_ignored();
      test_async_reset();
      test_sweep("sweep_after_rst", 1'b1, 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
